pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter WIDTH, default 64: bit width of each pattern word X and Y (8..64).
REQ-002 Parameter SEL_W, default 2: seed-select width; the seed bank holds 2**SEL_W entries.
REQ-003 Parameter MAX_STEPS, default 16: number of steps per round before DONE (1..255).
REQ-004 Parameter TAPS, default 64'hD800000000000000: Galois feedback mask; only the low WIDTH bits are used.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 load  input  1  single-cycle request to load a seed pair.
REQ-008 sel  input  SEL_W  seed index, sampled only when load=1.
REQ-009 step  input  1  single-cycle request to advance the pattern one step.
REQ-010 X  output  WIDTH  current X pattern word, registered.
REQ-011 Y  output  WIDTH  current Y pattern word, registered.
REQ-012 valid  output  1  X/Y hold a loaded pattern.
REQ-013 done  output  1  MAX_STEPS steps have been taken since the last load.
REQ-014 step_cnt  output  8  steps taken since the last load.

Function
REQ-015 States: IDLE (valid=0, done=0), ACTIVE (valid=1, done=0), DONE (valid=1, done=1).
REQ-016 load=1 in any state: next cycle X/Y = seed[sel] truncated to the low WIDTH bits, step_cnt=0, state=ACTIVE; latency 1 cycle.
REQ-017 Seed bank: index 0 X=3A71628D53C493E6 Y=FA276435902E7342; index 1 X=63975AC427013426 Y=A5698148E8724198; index 2 X=9347832EC5218348 Y=5932BE6129437853; index 3 X=642E49823752EC40 Y=F633623987562747 (hex).
REQ-018 Index i>=4: seed[i mod 4] rotated left by i bits, applied to both X and Y before truncation.
REQ-019 A truncated seed word equal to zero loads as 1 instead.
REQ-020 step=1 in ACTIVE: next cycle X and Y advance per REQ-030/031 and step_cnt increments by 1.
REQ-021 The step that makes step_cnt equal MAX_STEPS moves the state to DONE in the same cycle.
REQ-022 step in IDLE or DONE is ignored: X, Y and step_cnt hold.
REQ-023 load and step asserted in the same cycle: load wins and the step is discarded.
REQ-024 With no load and no step, all outputs hold their values.
REQ-025 sel is a don't-care when load=0.

Reset
REQ-026 rst_n=0 immediately forces X=0, Y=0, valid=0, done=0, step_cnt=0 and state IDLE, with no clock edge required.
REQ-027 Reset mid-round discards the round; after release the block stays in IDLE until the next load.
REQ-028 Deassertion of rst_n is synchronised to clk externally; the first load is honoured on the first rising edge after release.

Configuration
REQ-029 Macro PATTERN_GEN_LFSR_EN selects the step function.
REQ-030 Defined: each word steps as a Galois LFSR: shift right by 1; if the old LSB=1, XOR the result with TAPS[WIDTH-1:0].
REQ-031 Undefined: each word rotates left by 1 bit per step; the TAPS parameter is unused.

Verification
REQ-032 Reset, then load=1 sel=0 -> 1 cycle later valid=1, X=3A71628D53C493E6, Y=FA276435902E7342, step_cnt=0.
REQ-033 With LFSR_EN defined, after a sel=0 load, one step -> X=1D38B146A9E249F3 (old LSB=0, no XOR), step_cnt=1.
REQ-034 With LFSR_EN undefined, after a sel=0 load, one step -> X=74E2C51AA78927CC.
REQ-035 MAX_STEPS=16, 17 consecutive steps -> done=1 after the 16th step; the 17th is ignored, step_cnt=16, X/Y unchanged.
REQ-036 load sel=3 and step in the same cycle -> X=642E49823752EC40, step_cnt=0; separately, rst_n=0 mid-round -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pattern_gen_if.sv
// Request/pattern bus between a pattern_gen and its user.
interface pattern_gen_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEL_W = 2
);
  logic             load;
  logic [SEL_W-1:0] sel;
  logic             step;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             valid;
  logic             done;
  logic [7:0]       step_cnt;

  modport master (
    output load, sel, step,
    input  X, Y, valid, done, step_cnt
  );

  modport slave (
    input  load, sel, step,
    output X, Y, valid, done, step_cnt
  );
endinterface

// File: rtl/pattern_gen.sv
// Seeded X/Y pattern generator with a fixed step budget per round.
// Step function: rotate-left by default, Galois LFSR when PATTERN_GEN_LFSR_EN is defined.
module pattern_gen #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned MAX_STEPS = 16,
  parameter logic [63:0] TAPS      = 64'hD800000000000000
) (
  input  logic         clk,
  input  logic         rst_n,
  pattern_gen_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  if (WIDTH < 8 || WIDTH > 64 || MAX_STEPS < 1 || MAX_STEPS > 255 || $bits(TAPS) != 64)
  begin : g_param_chk
    $error("pattern_gen: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  function automatic logic [63:0] bank_word(input logic [1:0] idx, input logic is_y);
    logic [63:0] w;
    case (idx)
      2'd0:    w = is_y ? 64'hFA276435902E7342 : 64'h3A71628D53C493E6;
      2'd1:    w = is_y ? 64'hA5698148E8724198 : 64'h63975AC427013426;
      2'd2:    w = is_y ? 64'h5932BE6129437853 : 64'h9347832EC5218348;
      default: w = is_y ? 64'hF633623987562747 : 64'h642E49823752EC40;
    endcase
    return w;
  endfunction

  // Indices past the base bank reuse a base entry rotated by the index itself.
  function automatic logic [WIDTH-1:0] seed_word(input logic [SEL_W-1:0] s, input logic is_y);
    int unsigned      si;
    int unsigned      r;
    logic [63:0]      base;
    logic [63:0]      rot;
    logic [WIDTH-1:0] trunc;
    si    = 32'(s);
    base  = bank_word(2'(si % 4), is_y);
    r     = (si >= 4) ? (si % 64) : 0;
    rot   = (r == 0) ? base : ((base << r) | (base >> (64 - r)));
    trunc = WIDTH'(rot);
    return (trunc == '0) ? WIDTH'(1) : trunc;
  endfunction

  function automatic logic [WIDTH-1:0] step_word(input logic [WIDTH-1:0] w);
`ifdef PATTERN_GEN_LFSR_EN
    return (w >> 1) ^ (w[0] ? TAPS[WIDTH-1:0] : '0);
`else
    return {w[WIDTH-2:0], w[WIDTH-1]};
`endif
  endfunction

  // Next-state and datapath; load has priority over step.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    if (bus.load) begin
      x_d     = seed_word(bus.sel, 1'b0);
      y_d     = seed_word(bus.sel, 1'b1);
      cnt_d   = '0;
      state_d = ST_ACTIVE;
    end else if (bus.step && state_q == ST_ACTIVE) begin
      x_d   = step_word(x_q);
      y_d   = step_word(y_q);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == MAX_CNT) begin
        state_d = ST_DONE;
      end
    end
    valid_d = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.X        = x_q;
  assign bus.Y        = y_q;
  assign bus.valid    = valid_q;
  assign bus.done     = done_q;
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed table, corner sequences, random vs. model.
module tb_pattern_gen;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned MAX_STEPS = 16;
  localparam logic [63:0] TAPS      = 64'hD800000000000000;

`ifdef PATTERN_GEN_LFSR_EN
  localparam logic [63:0] X0_STEP1 = 64'h1D38B146A9E249F3;
`else
  localparam logic [63:0] X0_STEP1 = 64'h74E2C51AA78927CC;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_gen_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  pattern_gen #(
    .WIDTH(WIDTH), .SEL_W(SEL_W), .MAX_STEPS(MAX_STEPS), .TAPS(TAPS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_x, m_y;
  int          m_cnt;
  bit          m_valid, m_done;

  logic [63:0] bank_x [4] = '{64'h3A71628D53C493E6, 64'h63975AC427013426,
                              64'h9347832EC5218348, 64'h642E49823752EC40};
  logic [63:0] bank_y [4] = '{64'hFA276435902E7342, 64'hA5698148E8724198,
                              64'h5932BE6129437853, 64'hF633623987562747};

  function automatic logic [63:0] m_seed(int unsigned i, bit is_y);
    logic [63:0] w;
    w = is_y ? bank_y[i % 4] : bank_x[i % 4];
    if (i >= 4) begin
      for (int k = 0; k < int'(i); k++) w = (w << 1) | (w >> 63);
    end
    if (w == 64'd0) w = 64'd1;
    return w;
  endfunction

  function automatic logic [63:0] m_step(logic [63:0] w);
`ifdef PATTERN_GEN_LFSR_EN
    return (w % 2 == 1) ? ((w / 2) ^ TAPS) : (w / 2);
`else
    return (w * 2) + (w / 64'h8000000000000000);
`endif
  endfunction

  task automatic m_reset();
    m_x = '0; m_y = '0; m_cnt = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic m_clock(bit ld, int unsigned s, bit st);
    if (ld) begin
      m_x = m_seed(s, 0); m_y = m_seed(s, 1);
      m_cnt = 0; m_valid = 1; m_done = 0;
    end else if (st && m_valid && !m_done) begin
      m_x = m_step(m_x); m_y = m_step(m_y);
      m_cnt++;
      if (m_cnt == int'(MAX_STEPS)) m_done = 1;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_x"}, bus.X, m_x);
    chk({tag, "_y"}, bus.Y, m_y);
    chk({tag, "_valid"}, 64'(bus.valid), 64'(m_valid));
    chk({tag, "_done"}, 64'(bus.done), 64'(m_done));
    chk({tag, "_cnt"}, 64'(bus.step_cnt), 64'(m_cnt));
  endtask

  task automatic cycle(bit ld, logic [SEL_W-1:0] s, bit st, string tag);
    bus.load = ld; bus.sel = s; bus.step = st;
    @(posedge clk);
    m_clock(ld, int'(s), st);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit              load;
    logic [SEL_W-1:0] sel;
    bit              step;
    logic [63:0]     exp_x;
    logic [7:0]      exp_cnt;
    bit              exp_valid;
    bit              exp_done;
  } vec_t;

  vec_t vecs [6];
  logic [63:0] x_hold;

  initial begin
    vecs[0] = '{1, 3'd0, 0, 64'h3A71628D53C493E6, 8'd0, 1, 0};
    vecs[1] = '{0, 3'd5, 1, X0_STEP1,              8'd1, 1, 0};
    vecs[2] = '{1, 3'd3, 1, 64'h642E49823752EC40, 8'd0, 1, 0};
    vecs[3] = '{0, 3'd7, 0, 64'h642E49823752EC40, 8'd0, 1, 0};
    vecs[4] = '{1, 3'd1, 0, 64'h63975AC427013426, 8'd0, 1, 0};
    vecs[5] = '{1, 3'd4, 0, 64'hA71628D53C493E63, 8'd0, 1, 0};

    bus.load = 0; bus.sel = '0; bus.step = 0;
    m_reset();
    #1;
    chk_model("reset");
    @(posedge clk); #1;
    chk_model("reset_hold");
    rst_n = 1'b1;
    cycle(0, 3'd0, 1, "idle_step");

    // Directed table
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].load, vecs[i].sel, vecs[i].step, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_xc", i), bus.X, vecs[i].exp_x);
      chk($sformatf("tbl%0d_cntc", i), 64'(bus.step_cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("tbl%0d_vc", i), 64'(bus.valid), 64'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d_dc", i), 64'(bus.done), 64'(vecs[i].exp_done));
    end

    // Seventeen steps: done on the 16th, 17th ignored
    cycle(1, 3'd0, 0, "run_load");
    x_hold = '0;
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 3'd0, 1, $sformatf("run%0d", i));
      chk($sformatf("run%0d_done", i), 64'(bus.done), (i >= 16) ? 64'd1 : 64'd0);
      chk($sformatf("run%0d_cnt", i), 64'(bus.step_cnt), (i >= 16) ? 64'd16 : 64'(i));
      if (i == 16) x_hold = bus.X;
    end
    chk("run17_xhold", bus.X, x_hold);

    // Asynchronous reset mid-round
    cycle(1, 3'd2, 0, "mid_load");
    cycle(0, 3'd0, 1, "mid_step");
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_model("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(0, 3'd0, 1, "post_rst_step");
    cycle(0, 3'd0, 0, "post_rst_idle");
    cycle(1, 3'd6, 0, "post_rst_load");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) == 0), SEL_W'($urandom), ($urandom_range(0, 3) != 0),
            $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
